// File: rtl/accum_buffer_if.sv
// Stream bundle between a systolic column, its accumulation buffer and the writeback path.
// The slave side is the buffer: it sinks partial sums and sources final sums.
interface accum_buffer_if #(
   parameter int OFMAP_WIDTH = 32,
   parameter int ACC_WIDTH   = 32
);
   logic                          in_valid;
   logic signed [OFMAP_WIDTH-1:0] in_data;
   logic                          out_valid;
   logic                          out_ready;
   logic signed [ACC_WIDTH-1:0]   out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output out_valid, out_data
   );
endinterface

// File: rtl/accum_buffer.sv
// Per-column partial-sum accumulation buffer: sums num_passes tiles into a small bank, then drains it.
// Define ACCUM_BUF_SAT_EN to saturate accumulation sums instead of letting them wrap.
module accum_buffer #(
   parameter int OFMAP_WIDTH = 32,
   parameter int ACC_WIDTH   = 32,
   parameter int BANK_DEPTH  = 16,
   parameter int ADDR_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  config_en,
   input  logic [7:0]            config_num_passes,
   input  logic [ADDR_WIDTH:0]   config_num_elems,
   accum_buffer_if.slave         bus,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH:0]   ELEMS_ONE  = 1;
   localparam logic [ADDR_WIDTH:0]   ELEMS_MAX  = (ADDR_WIDTH+1)'(BANK_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = 1;

   state_t                 state, state_next;
   logic [ADDR_WIDTH-1:0]  elem_cnt, elem_next;
   logic [7:0]             pass_cnt, pass_next;
   logic [7:0]             num_passes, passes_next;
   logic [ADDR_WIDTH:0]    num_elems, elems_next;
   logic                   done_next;
   logic                   mem_we;
   logic                   cfg_legal;
   logic                   elem_last;
   logic                   pass_last;

   logic signed [ACC_WIDTH-1:0] mem [BANK_DEPTH];
   logic signed [ACC_WIDTH-1:0] mem_rd;
   logic signed [ACC_WIDTH-1:0] in_ext;
   logic signed [ACC_WIDTH-1:0] sum_raw;
   logic signed [ACC_WIDTH-1:0] sum;
   logic signed [ACC_WIDTH-1:0] mem_wdata;

   assign cfg_legal = (config_num_passes != 8'd0) && (config_num_elems != '0) &&
                      (config_num_elems <= ELEMS_MAX);
   assign elem_last = (({1'b0, elem_cnt} + ELEMS_ONE) == num_elems);
   assign pass_last = ((pass_cnt + 8'd1) == num_passes);

   assign mem_rd  = mem[elem_cnt];
   assign in_ext  = ACC_WIDTH'($signed(bus.in_data));
   assign sum_raw = mem_rd + in_ext;

`ifdef ACCUM_BUF_SAT_EN
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
   logic ovf;

   // Same-sign operands producing an opposite-sign result is the only overflow case.
   assign ovf = (mem_rd[ACC_WIDTH-1] == in_ext[ACC_WIDTH-1]) &&
                (sum_raw[ACC_WIDTH-1] != mem_rd[ACC_WIDTH-1]);
   assign sum = ovf ? (mem_rd[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX) : sum_raw;
`else
   assign sum = sum_raw;
`endif

   // Pass 0 overwrites so whatever the bank held before this job never reaches a result.
   assign mem_wdata = (pass_cnt == 8'd0) ? in_ext : sum;

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[elem_cnt] <= mem_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         elem_cnt   <= '0;
         pass_cnt   <= '0;
         num_passes <= '0;
         num_elems  <= '0;
         done       <= 1'b0;
      end else begin
         state      <= state_next;
         elem_cnt   <= elem_next;
         pass_cnt   <= pass_next;
         num_passes <= passes_next;
         num_elems  <= elems_next;
         done       <= done_next;
      end
   end

   always_comb begin
      state_next  = state;
      elem_next   = elem_cnt;
      pass_next   = pass_cnt;
      passes_next = num_passes;
      elems_next  = num_elems;
      done_next   = 1'b0;
      mem_we      = 1'b0;
      case (state)
         IDLE: begin
            if (config_en && cfg_legal) begin
               passes_next = config_num_passes;
               elems_next  = config_num_elems;
               elem_next   = '0;
               pass_next   = '0;
               state_next  = ACCUM;
            end
         end
         ACCUM: begin
            if (bus.in_valid) begin
               mem_we = 1'b1;
               if (elem_last) begin
                  elem_next = '0;
                  if (pass_last)
                     state_next = DRAIN;
                  else
                     pass_next = pass_cnt + 8'd1;
               end else begin
                  elem_next = elem_cnt + ADDR_ONE;
               end
            end
         end
         DRAIN: begin
            if (bus.out_ready) begin
               if (elem_last) begin
                  elem_next  = '0;
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  elem_next = elem_cnt + ADDR_ONE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy          = (state != IDLE);
   assign bus.out_valid = (state == DRAIN);
   assign bus.out_data  = (state == DRAIN) ? mem_rd : '0;

endmodule

// File: tb/tb_accum_buffer.sv
// Directed bench for accum_buffer: a 32-bit-input instance for most jobs and a 16-bit-input
// instance for the sign-extension/backpressure job.
module tb_accum_buffer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cfg_en_a = 1'b0;
   logic       cfg_en_b = 1'b0;
   logic [7:0] cfg_passes = '0;
   logic [4:0] cfg_elems = '0;
   logic       busy_a, done_a, busy_b, done_b;

   int compared   = 0;
   int mismatched = 0;

   accum_buffer_if #(.OFMAP_WIDTH(32), .ACC_WIDTH(32)) bus_a ();
   accum_buffer_if #(.OFMAP_WIDTH(16), .ACC_WIDTH(32)) bus_b ();

   accum_buffer #(.OFMAP_WIDTH(32), .ACC_WIDTH(32), .BANK_DEPTH(16), .ADDR_WIDTH(4)) dut_a (
      .clk               (clk),
      .rst               (rst),
      .config_en         (cfg_en_a),
      .config_num_passes (cfg_passes),
      .config_num_elems  (cfg_elems),
      .bus               (bus_a),
      .busy              (busy_a),
      .done              (done_a)
   );

   accum_buffer #(.OFMAP_WIDTH(16), .ACC_WIDTH(32), .BANK_DEPTH(16), .ADDR_WIDTH(4)) dut_b (
      .clk               (clk),
      .rst               (rst),
      .config_en         (cfg_en_b),
      .config_num_passes (cfg_passes),
      .config_num_elems  (cfg_elems),
      .bus               (bus_b),
      .busy              (busy_b),
      .done              (done_b)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic configure(input bit sel_b, input logic [7:0] passes, input logic [4:0] elems);
      cfg_passes = passes;
      cfg_elems  = elems;
      if (sel_b) cfg_en_b = 1'b1;
      else       cfg_en_a = 1'b1;
      tick();
      cfg_en_a = 1'b0;
      cfg_en_b = 1'b0;
   endtask

   task automatic applyStimulus(input bit sel_b, input logic [31:0] data);
      if (sel_b) begin
         bus_b.in_valid = 1'b1;
         bus_b.in_data  = data[15:0];
      end else begin
         bus_a.in_valid = 1'b1;
         bus_a.in_data  = data;
      end
      tick();
      bus_a.in_valid = 1'b0;
      bus_b.in_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] exp_a [4];
      logic [31:0] exp_b [5];
      logic        rdy_b [5];

      bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
      bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;

      // Reset values
      #1 rst = 1'b1;
      #1;
      checkOutput("reset_busy", 32'(busy_a), 32'd0);
      checkOutput("reset_done", 32'(done_a), 32'd0);
      checkOutput("reset_out_valid", 32'(bus_a.out_valid), 32'd0);
      checkOutput("reset_out_data", bus_a.out_data, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Basic accumulate and drain: passes=2, elems=4
      configure(1'b0, 8'd2, 5'd4);
      checkOutput("basic_busy_rise", 32'(busy_a), 32'd1);
      applyStimulus(1'b0, 32'd1);  applyStimulus(1'b0, 32'd2);
      applyStimulus(1'b0, 32'd3);  applyStimulus(1'b0, 32'd4);
      applyStimulus(1'b0, 32'd10); applyStimulus(1'b0, 32'd20);
      applyStimulus(1'b0, 32'd30); applyStimulus(1'b0, 32'd40);
      bus_a.out_ready = 1'b1;
      exp_a = '{32'd11, 32'd22, 32'd33, 32'd44};
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("basic_valid_%0d", i), 32'(bus_a.out_valid), 32'd1);
         checkOutput($sformatf("basic_data_%0d", i), bus_a.out_data, exp_a[i]);
         tick();
      end
      checkOutput("basic_done", 32'(done_a), 32'd1);
      checkOutput("basic_busy_fall", 32'(busy_a), 32'd0);
      checkOutput("basic_out_data_idle", bus_a.out_data, 32'd0);
      tick();
      checkOutput("basic_done_pulse", 32'(done_a), 32'd0);

      // Backpressure and sign extension on the 16-bit instance
      configure(1'b1, 8'd1, 5'd3);
      applyStimulus(1'b1, 32'h0000FFFB);
      applyStimulus(1'b1, 32'h0000FFFA);
      applyStimulus(1'b1, 32'h0000FFF9);
      rdy_b = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      exp_b = '{32'hFFFFFFFB, 32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFF9};
      for (int i = 0; i < 5; i++) begin
         bus_b.out_ready = rdy_b[i];
         checkOutput($sformatf("bp_valid_%0d", i), 32'(bus_b.out_valid), 32'd1);
         checkOutput($sformatf("bp_data_%0d", i), bus_b.out_data, exp_b[i]);
         tick();
      end
      bus_b.out_ready = 1'b0;
      checkOutput("bp_done", 32'(done_b), 32'd1);
      checkOutput("bp_busy", 32'(busy_b), 32'd0);

      // Single entry, back-to-back beats
      configure(1'b0, 8'd3, 5'd1);
      applyStimulus(1'b0, 32'd7);
      applyStimulus(1'b0, 32'd8);
      applyStimulus(1'b0, 32'd9);
      checkOutput("single_valid", 32'(bus_a.out_valid), 32'd1);
      checkOutput("single_data", bus_a.out_data, 32'd24);
      tick();
      checkOutput("single_done", 32'(done_a), 32'd1);
      tick();

      // Illegal configurations are ignored
      configure(1'b0, 8'd2, 5'd0);
      checkOutput("illegal_elems0_busy", 32'(busy_a), 32'd0);
      configure(1'b0, 8'd2, 5'd17);
      checkOutput("illegal_elems17_busy", 32'(busy_a), 32'd0);
      configure(1'b0, 8'd0, 5'd4);
      checkOutput("illegal_passes0_busy", 32'(busy_a), 32'd0);

      // Idle gaps between beats; entry 0 still holds 24 from the previous job
      configure(1'b0, 8'd2, 5'd2);
      applyStimulus(1'b0, 32'd100);
      tick();
      applyStimulus(1'b0, 32'd200);
      tick(); tick();
      applyStimulus(1'b0, 32'd5);
      tick();
      checkOutput("gap_still_accum", 32'(bus_a.out_valid), 32'd0);
      applyStimulus(1'b0, 32'd6);
      checkOutput("gap_data_0", bus_a.out_data, 32'd105);
      tick();
      checkOutput("gap_data_1", bus_a.out_data, 32'd206);
      tick();
      checkOutput("gap_done", 32'(done_a), 32'd1);

      // Overflow at the accumulator width
      configure(1'b0, 8'd2, 5'd1);
      applyStimulus(1'b0, 32'h7FFFFFFF);
      applyStimulus(1'b0, 32'h00000001);
`ifdef ACCUM_BUF_SAT_EN
      checkOutput("overflow_sat", bus_a.out_data, 32'h7FFFFFFF);
`else
      checkOutput("overflow_wrap", bus_a.out_data, 32'h80000000);
`endif
      tick();
      checkOutput("overflow_done", 32'(done_a), 32'd1);
      bus_a.out_ready = 1'b0;

      // Asynchronous reset during ACCUM
      configure(1'b0, 8'd2, 5'd2);
      applyStimulus(1'b0, 32'd1);
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_accum_busy", 32'(busy_a), 32'd0);
      checkOutput("rst_accum_valid", 32'(bus_a.out_valid), 32'd0);
      #1 rst = 1'b0;
      tick();

      // Asynchronous reset during DRAIN
      configure(1'b0, 8'd1, 5'd2);
      applyStimulus(1'b0, 32'd3);
      applyStimulus(1'b0, 32'd4);
      checkOutput("pre_rst_drain_data", bus_a.out_data, 32'd3);
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_drain_valid", 32'(bus_a.out_valid), 32'd0);
      checkOutput("rst_drain_data", bus_a.out_data, 32'd0);
      checkOutput("rst_drain_busy", 32'(busy_a), 32'd0);
      checkOutput("rst_drain_done", 32'(done_a), 32'd0);
      #1 rst = 1'b0;
      tick();

      // Job after reset completes normally
      configure(1'b0, 8'd1, 5'd2);
      applyStimulus(1'b0, 32'd50);
      applyStimulus(1'b0, 32'd60);
      bus_a.out_ready = 1'b1;
      checkOutput("post_rst_data_0", bus_a.out_data, 32'd50);
      tick();
      checkOutput("post_rst_data_1", bus_a.out_data, 32'd60);
      tick();
      checkOutput("post_rst_done", 32'(done_a), 32'd1);
      bus_a.out_ready = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/accum_buffer.md
# accum_buffer

Output-side partial-sum accumulation buffer for one systolic-array column. It consumes the `ofmap_out` stream leaving the bottom MAC of the column and accumulates it into a small register-file bank across `num_passes` input-channel tiles. It then drains the final sums to the writeback path over a valid/ready handshake. One instance sits directly below each array column.

## Interface

Parameters:

- `OFMAP_WIDTH`, 32, width of the incoming partial sum from the MAC column.
- `ACC_WIDTH`, 32, accumulator and output width; must be ≥ `OFMAP_WIDTH`.
- `BANK_DEPTH`, 16, number of accumulator entries.
- `ADDR_WIDTH`, 4, `$clog2(BANK_DEPTH)`.

Ports:

- `clk` input, 1: the single clock; all state changes on the rising edge.
- `rst` input, 1: reset, asynchronous, active-high.
- `config_en` input, 1: latch the configuration (honoured only in IDLE).
- `config_num_passes` input, 8: number of accumulation passes; legal range 1..255.
- `config_num_elems` input, `ADDR_WIDTH+1`: entries per pass; legal range 1..`BANK_DEPTH`.
- `in_valid` input, 1: `in_data` is a valid partial sum this cycle.
- `in_data` input, `OFMAP_WIDTH`, signed: partial sum from the MAC column.
- `out_valid` output, 1: `out_data` holds a final sum.
- `out_ready` input, 1: the consumer accepts `out_data`.
- `out_data` output, `ACC_WIDTH`, signed: final accumulated sum.
- `busy` output, 1: high in ACCUM and DRAIN.
- `done` output, 1: one-cycle pulse after the last drain transfer.

## Operation

State machine with three states:

- **IDLE**
  - `config_en` with legal values: latch `num_passes` and `num_elems`, clear `elem_cnt` and `pass_cnt`, go to ACCUM.
  - `config_en` with illegal values (0 in either field, or `num_elems` > `BANK_DEPTH`): ignored; stay in IDLE.
  - `in_valid` is ignored.
- **ACCUM**
  - There is no input backpressure: every `in_valid` beat is consumed.
  - Each beat targets `mem[elem_cnt]`. When `pass_cnt` = 0 it writes `sext(in_data)`; otherwise it writes `mem[elem_cnt] + sext(in_data)`.
  - The read-modify-write completes within the same cycle.
  - `elem_cnt` increments per beat. At `num_elems-1` it wraps to 0 and `pass_cnt` increments.
  - The beat with `pass_cnt` = `num_passes-1` and `elem_cnt` = `num_elems-1` moves the FSM to DRAIN and clears `elem_cnt`.
  - Cycles without `in_valid` change nothing.
  - `config_en` is ignored.
- **DRAIN**
  - `out_valid` = 1 and `out_data` = `mem[elem_cnt]`.
  - On `out_valid && out_ready`, `elem_cnt` increments.
  - The transfer at `elem_cnt` = `num_elems-1` returns the FSM to IDLE and pulses `done` for the following cycle.
  - `in_valid` is ignored: beats arriving during DRAIN are dropped.
- **Arithmetic**
  - Two's-complement addition, wrapping at `ACC_WIDTH` (see Configuration).
  - `in_data` is sign-extended to `ACC_WIDTH`.
- **Memory**
  - `mem` is not reset.
  - Pass 0 overwrites each entry, so stale contents never leak into a result.
- **`out_data` outside DRAIN** is 0.

## Timing

- Reset values: state IDLE, counters 0, `out_valid` 0, `out_data` 0, `busy` 0, `done` 0.
- Reset mid-operation aborts immediately; any partial results are discarded.
- `config_en` at edge t puts the FSM in ACCUM at t+1. `busy` rises in the same cycle.
- Input-to-storage latency: the beat at edge t is visible in `mem` from t+1.
- Back-to-back beats to the same entry (`num_elems` = 1) accumulate correctly.
- The final ACCUM beat at edge t gives `out_valid` = 1 with entry 0 in cycle t+1.
- Drain throughput is one entry per cycle while `out_ready` is held high.
- While `out_valid` is high, `out_data` holds stable until the transfer; `out_valid` never drops without a transfer.
- The final drain transfer at edge t gives `busy` = 0 and `done` = 1 at t+1; `done` = 0 at t+2.
- A new `config_en` is accepted in that t+1 cycle, so `done` and a new start may coincide.

## Configuration

- `ACCUM_BUF_SAT_EN` defined:
  - Each pass ≥ 1 sum saturates to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1] instead of wrapping.
  - Overflow is detected from the operand signs and the result sign.
- `ACCUM_BUF_SAT_EN` undefined: plain wrapping addition, with no saturation logic.

## Test plan

- **Basic accumulate-and-drain:** configure passes=2, elems=4; beats 1,2,3,4 then 10,20,30,40; `out_ready`=1 → `out_data` 11,22,33,44 on four consecutive cycles, then a one-cycle `done`, `busy`=0.
- **Backpressure and sign extension:** configure passes=1, elems=3 with negative `in_data` (−5 with `OFMAP_WIDTH`=16, `ACC_WIDTH`=32); toggle `out_ready` 1,0,0,1,1 → `out_data` = −5 sign-extended; `out_data` holds while `out_ready`=0; exactly 3 transfers.
- **Single-entry back-to-back:** configure passes=3, elems=1; beats 7,8,9 on consecutive cycles → a single output of 24.
- **Gaps, stale data and illegal config:**
  - Leave idle gaps between `in_valid` beats → the result is unchanged.
  - Run a second job after the first → no stale contents leak into the result.
  - Issue `config_en` with elems=0, then with elems=17 → FSM stays in IDLE, `busy`=0.
- **Overflow:** passes=2, elems=1, beats 0x7FFFFFFF then 1 → output 0x80000000 without `ACCUM_BUF_SAT_EN`, 0x7FFFFFFF with it.
- **Reset mid-operation:** assert `rst` asynchronously mid-ACCUM and mid-DRAIN → all outputs are 0 and the FSM is in IDLE without waiting for a clock edge; the next job completes correctly.
